// File: rtl/idp_sequencer.sv
// idp_sequencer: multi-cycle control sequencer for the integer datapath.
//
// It takes one 16-bit instruction per start/done handshake. It then steps
// through DECODE, EXECUTE, WRITE and DONE to drive register-file addresses,
// the write enable, the ALU op and the S-mux select. It also counts the
// instructions that complete.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   start        request to execute instr (sampled only when accepted)
//   instr[15:0]  [15:12] op, [11:9] W_Adr, [8:6] R_Adr, [5:3] S_Adr,
//                [2] S_Sel, [1:0] reserved
//   busy         instruction in flight (DECODE..DONE)
//   done         one-cycle completion pulse (DONE)
//   W_En         register-file write enable (WRITE only)
//   W_Adr        write address (EXECUTE, WRITE)
//   R_Adr/S_Adr  read addresses (DECODE..WRITE)
//   S_Sel        0 = register S operand, 1 = external DS (DECODE..WRITE)
//   Alu_Op       ALU operation (DECODE..WRITE)
//   instr_count  completed-instruction counter, wraps
//
// Build option: defining IDP_SEQ_PENDING_EN adds a one-entry pending buffer.
// The buffer accepts a start while busy, which allows back-to-back issue
// every 4 cycles. In the default build, a start while busy is ignored.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for start
// DECODE  | read controls driven from ir
// EXECUTE | read controls held, write address driven
// WRITE   | W_En asserted for this single cycle
// DONE    | done pulse; counter bumps on the exit edge

module idp_sequencer #(
  parameter int OP_W  = 4,
  parameter int ADR_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      instr,
  output logic             busy,
  output logic             done,
  output logic             W_En,
  output logic [ADR_W-1:0] W_Adr,
  output logic [ADR_W-1:0] R_Adr,
  output logic [ADR_W-1:0] S_Adr,
  output logic             S_Sel,
  output logic [OP_W-1:0]  Alu_Op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  // Only bits [15:2] are kept; the two reserved bits never reach the datapath.
  logic [15:2]        ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic unused_rsvd;
  assign unused_rsvd = ^instr[1:0];

`ifdef IDP_SEQ_PENDING_EN
  logic               pend_valid_q, pend_valid_d;
  logic [15:2]        pend_instr_q, pend_instr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_instr_q <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_instr_q <= pend_instr_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
`ifdef IDP_SEQ_PENDING_EN
    pend_valid_d = pend_valid_q;
    pend_instr_d = pend_instr_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef IDP_SEQ_PENDING_EN
        // A start captured during the final DONE cycle lands here.
        // Drain it before looking at a fresh start.
        if (pend_valid_q) begin
          state_d      = DECODE;
          ir_d         = pend_instr_q;
          pend_valid_d = 1'b0;
        end else
`endif
        if (start) begin
          state_d = DECODE;
          ir_d    = instr[15:2];
        end
      end
      DECODE:  state_d = EXECUTE;
      EXECUTE: state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
`ifdef IDP_SEQ_PENDING_EN
        if (pend_valid_q) begin
          state_d      = DECODE;
          ir_d         = pend_instr_q;
          pend_valid_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef IDP_SEQ_PENDING_EN
    // Uses the registered pend_valid. A start in the same DONE cycle that
    // drains the buffer is therefore dropped, not stored.
    if (start && (state_q != IDLE) && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_instr_d = instr[15:2];
    end
`endif
  end

  // Outputs are pure decodes of registered state. Because of that, reset
  // kills W_En without waiting for a clock edge.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    W_En   = 1'b0;
    W_Adr  = '0;
    R_Adr  = '0;
    S_Adr  = '0;
    S_Sel  = 1'b0;
    Alu_Op = '0;
    case (state_q)
      DECODE, EXECUTE, WRITE: begin
        busy   = 1'b1;
        R_Adr  = ADR_W'(ir_q[8:6]);
        S_Adr  = ADR_W'(ir_q[5:3]);
        S_Sel  = ir_q[2];
        Alu_Op = OP_W'(ir_q[15:12]);
        if (state_q != DECODE) W_Adr = ADR_W'(ir_q[11:9]);
        if (state_q == WRITE)  W_En  = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr_count = cnt_q;

endmodule

// File: tb/tb_idp_sequencer.sv
module tb_idp_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic        busy, done, W_En, S_Sel;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic [3:0]  Alu_Op;
  logic [7:0]  instr_count;

  idp_sequencer #(.OP_W(4), .ADR_W(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .busy(busy), .done(done), .W_En(W_En), .W_Adr(W_Adr),
    .R_Adr(R_Adr), .S_Adr(S_Adr), .S_Sel(S_Sel), .Alu_Op(Alu_Op),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen; the period after edge e has cyc == e.
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] ins;
    int          acc;   // edge at which the instruction was accepted
  } txn_t;

  txn_t q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   model_cnt = 0;
  int   last_acc  = -100;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Called at a falling edge. It presents start/instr for the next rising
  // edge and returns at the following falling edge. The reference rule is
  // that an instruction takes DECODE, EXECUTE, WRITE, DONE, then one IDLE
  // cycle, so a new accept needs at least 5 edges since the last one.
  task automatic drive(input bit s, input logic [15:0] i);
    start = s;
    instr = i;
    if (s && !reset && (cyc + 1 >= last_acc + 5)) begin
      q.push_back('{ins: i, acc: cyc + 1});
      last_acc = cyc + 1;
    end
    @(negedge clk);
  endtask

  task automatic flush_model();
    q.delete();
    model_cnt = 0;
    last_acc  = -100;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_wen"},   W_En, 0);
    check({tag, "_radr"},  R_Adr, 0);
    check({tag, "_op"},    Alu_Op, 0);
    check({tag, "_count"}, instr_count, 0);
  endtask

  task automatic reset_pulse();
    start = 1'b0;
    reset = 1'b1;
    flush_model();
    #2 check_reset_outputs("rst_idle");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Assert reset asynchronously in the middle of a WRITE cycle.
  task automatic reset_in_write(input logic [15:0] i);
    drive(1'b1, i);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("wen_before_reset", W_En, 1);
    #1 reset = 1'b1;
    flush_model();
    #1 check_reset_outputs("rst_write");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: retire finished instructions, then compare every output
  // against what the head instruction's phase requires.
  always @(negedge clk) begin
    if (!reset) begin
      int          d;
      logic [15:0] ins;
      logic        e_busy, e_done, e_wen, e_sel;
      logic [2:0]  e_w, e_r, e_s;
      logic [3:0]  e_op;
      while (q.size() > 0 && cyc >= q[0].acc + 4) begin
        void'(q.pop_front());
        model_cnt = (model_cnt + 1) % 256;
      end
      e_busy = 0; e_done = 0; e_wen = 0; e_sel = 0;
      e_w = 0; e_r = 0; e_s = 0; e_op = 0;
      if (q.size() > 0 && cyc >= q[0].acc) begin
        d      = cyc - q[0].acc;
        ins    = q[0].ins;
        e_busy = 1;
        if (d <= 2) begin
          e_r  = ins[8:6];
          e_s  = ins[5:3];
          e_sel = ins[2];
          e_op = ins[15:12];
        end
        if (d == 1 || d == 2) e_w = ins[11:9];
        e_wen  = (d == 2);
        e_done = (d == 3);
      end
      check("busy",   busy,   e_busy);
      check("done",   done,   e_done);
      check("w_en",   W_En,   e_wen);
      check("w_adr",  W_Adr,  e_w);
      check("r_adr",  R_Adr,  e_r);
      check("s_adr",  S_Adr,  e_s);
      check("s_sel",  S_Sel,  e_sel);
      check("alu_op", Alu_Op, e_op);
      check("count",  instr_count, model_cnt[7:0]);
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    instr = 16'h0000;
    #3 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    drive(1'b1, 16'h3A50);
    repeat (5) drive(1'b0, 16'hFFFF);
    drive(1'b1, 16'h1E3C);
    repeat (5) drive(1'b0, 16'h0000);

    // The second start lands during EXECUTE and must be ignored.
    drive(1'b1, 16'h5554);
    drive(1'b0, 16'h0000);
    drive(1'b1, 16'h7778);
    repeat (6) drive(1'b0, 16'h0000);

    reset_in_write(16'hBEEF);
    repeat (2) drive(1'b0, 16'h0000);

    repeat (400) drive(1'($urandom_range(0, 1)), 16'($urandom));
    repeat (6) drive(1'b0, 16'h0000);

    // start held high: the counter must wrap to 0 on the 256th completion.
    reset_pulse();
    repeat (260 * 5) drive(1'b1, 16'($urandom));
    repeat (6) drive(1'b0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
